// File: rtl/riscv_defs.sv
// Shared definitions for the byte-serial memory controller: size codes,
// requester ids, FSM state encoding and a size decode helper.
package riscv_defs;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_MM = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StXfer,
      StTail,
      StDone
   } mc_state_e;

   // Index of the last byte of an access; size 11 is handled as a word.
   function automatic logic [1:0] last_byte(input logic [1:0] size);
      logic [1:0] res;
      case (size)
         SZ_B:    res = 2'd0;
         SZ_H:    res = 2'd1;
         default: res = 2'd3;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side handshake bundle of the memory controller: fetch and
// memory-stage request/response signals plus the per-stage stall requests.
interface mem_ctrl_if;

   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;

   logic        mm_req;
   logic        mm_we;
   logic [1:0]  mm_size;
   logic        mm_sext;
   logic [31:0] mm_addr;
   logic [31:0] mm_wdata;
   logic        mm_done;
   logic [31:0] mm_rdata;

   logic        stl_if;
   logic        stl_mm;

   // Pipeline side: issues requests, receives results and stalls.
   modport master (
      output if_req, if_addr, mm_req, mm_we, mm_size, mm_sext, mm_addr, mm_wdata,
      input  if_done, if_data, mm_done, mm_rdata, stl_if, stl_mm
   );

   // Controller side.
   modport slave (
      input  if_req, if_addr, mm_req, mm_we, mm_size, mm_sext, mm_addr, mm_wdata,
      output if_done, if_data, mm_done, mm_rdata, stl_if, stl_mm
   );

endinterface

// File: rtl/mem_ctrl.sv
// Single-port memory controller/arbiter. Serialises fetch and memory-stage
// accesses into byte cycles on a synchronous byte-wide RAM; the memory stage
// wins ties. Read bytes are assembled little-endian and optionally sign-extended.
module mem_ctrl
   import riscv_defs::*;
#(
   parameter int unsigned RAM_AW = 17
) (
   input  logic              clk,
   input  logic              rst,
   mem_ctrl_if.slave         bus,
   output logic [RAM_AW-1:0] ram_a,
   output logic              ram_wr,
   output logic [7:0]        ram_dout,
   input  logic [7:0]        ram_din
);

   mc_state_e         state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sext_q, sext_d;
   logic [31:0]       addr_q, addr_d;    // address of the next byte to present
   logic [31:0]       wdata_q, wdata_d;  // store data, shifted down one byte per cycle
   logic [1:0]        cnt_q, cnt_d;      // byte index k currently on the RAM port
   logic [31:0]       buf_q, buf_d;
   logic              if_done_q, if_done_d;
   logic              mm_done_q, mm_done_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       mm_rdata_q, mm_rdata_d;
   logic [RAM_AW-1:0] ram_a_q, ram_a_d;
   logic              ram_wr_q, ram_wr_d;
   logic [7:0]        ram_dout_q, ram_dout_d;

   // Granted-request view: memory stage has fixed priority over fetch.
   logic        g_mm;
   logic        g_we;
   logic [1:0]  g_size;
   logic        g_sext;
   logic [31:0] g_addr;
   logic [31:0] g_wdata;
   logic [31:0] rd_full;
   logic [31:0] rd_ext;

   assign g_mm    = bus.mm_req;
   assign g_we    = g_mm & bus.mm_we;
   assign g_size  = g_mm ? bus.mm_size : SZ_W;
   assign g_sext  = g_mm & bus.mm_sext;
   assign g_addr  = g_mm ? bus.mm_addr : bus.if_addr;
   assign g_wdata = g_mm ? bus.mm_wdata : 32'h0;

   // Merge the final byte arriving from the RAM and extend to 32 bits.
   always_comb begin
      rd_full = buf_q;
      rd_full[{cnt_q, 3'b000} +: 8] = ram_din;
      case (size_q)
         SZ_B:    rd_ext = {{24{sext_q & rd_full[7]}}, rd_full[7:0]};
         SZ_H:    rd_ext = {{16{sext_q & rd_full[15]}}, rd_full[15:0]};
         default: rd_ext = rd_full;
      endcase
   end

   // Next-state and registered-output logic of the transfer FSM.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      size_d     = size_q;
      sext_d     = sext_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      if_done_d  = 1'b0;
      mm_done_d  = 1'b0;
      if_data_d  = if_data_q;
      mm_rdata_d = mm_rdata_q;
      ram_a_d    = ram_a_q;
      ram_wr_d   = 1'b0;
      ram_dout_d = ram_dout_q;

      unique case (state_q)
         StIdle: begin
            if (bus.mm_req || bus.if_req) begin
               state_d    = StXfer;
               req_d      = g_mm ? REQ_MM : REQ_IF;
               we_d       = g_we;
               size_d     = g_size;
               sext_d     = g_sext;
               cnt_d      = 2'd0;
               buf_d      = 32'h0;
               // Present byte 0 on the next cycle.
               ram_a_d    = g_addr[RAM_AW-1:0];
               ram_wr_d   = g_we;
               ram_dout_d = g_wdata[7:0];
               addr_d     = g_addr + 32'd1;
               wdata_d    = g_wdata >> 8;
            end
         end

         StXfer: begin
            // RAM returns byte k-1 while byte k is being addressed.
            if (!we_q && cnt_q != 2'd0) begin
               buf_d[{cnt_q - 2'd1, 3'b000} +: 8] = ram_din;
            end
            if (cnt_q == last_byte(size_q)) begin
               if (we_q) begin
                  state_d   = StDone;
                  mm_done_d = (req_q == REQ_MM);
                  if_done_d = (req_q == REQ_IF);
               end else begin
                  state_d = StTail;
               end
            end else begin
               cnt_d      = cnt_q + 2'd1;
               ram_a_d    = addr_q[RAM_AW-1:0];
               ram_wr_d   = we_q;
               ram_dout_d = wdata_q[7:0];
               addr_d     = addr_q + 32'd1;
               wdata_d    = wdata_q >> 8;
            end
         end

         StTail: begin
            state_d = StDone;
            if (req_q == REQ_MM) begin
               mm_done_d  = 1'b1;
               mm_rdata_d = rd_ext;
            end else begin
               if_done_d = 1'b1;
               if_data_d = rd_ext;
            end
         end

         StDone: begin
            // Requests are deliberately not sampled here.
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         req_q      <= REQ_IF;
         we_q       <= 1'b0;
         size_q     <= SZ_B;
         sext_q     <= 1'b0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         cnt_q      <= 2'd0;
         buf_q      <= 32'h0;
         if_done_q  <= 1'b0;
         mm_done_q  <= 1'b0;
         if_data_q  <= 32'h0;
         mm_rdata_q <= 32'h0;
         ram_a_q    <= '0;
         ram_wr_q   <= 1'b0;
         ram_dout_q <= 8'h0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         size_q     <= size_d;
         sext_q     <= sext_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         if_done_q  <= if_done_d;
         mm_done_q  <= mm_done_d;
         if_data_q  <= if_data_d;
         mm_rdata_q <= mm_rdata_d;
         ram_a_q    <= ram_a_d;
         ram_wr_q   <= ram_wr_d;
         ram_dout_q <= ram_dout_d;
      end
   end

   assign ram_a        = ram_a_q;
   assign ram_wr       = ram_wr_q;
   assign ram_dout     = ram_dout_q;
   assign bus.if_done  = if_done_q;
   assign bus.if_data  = if_data_q;
   assign bus.mm_done  = mm_done_q;
   assign bus.mm_rdata = mm_rdata_q;
   assign bus.stl_if   = bus.if_req & ~if_done_q;
   assign bus.stl_mm   = bus.mm_req & ~mm_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural byte RAM, scoreboard of
// expected completions, vector table for loads/stores, directed corner cases.
module tb_mem_ctrl;

   localparam int unsigned AW = 17;

   logic          clk;
   logic          rst;
   logic [AW-1:0] ram_a;
   logic          ram_wr;
   logic [7:0]    ram_dout;
   logic [7:0]    ram_din;

   mem_ctrl_if bus ();

   mem_ctrl #(.RAM_AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .ram_a    (ram_a),
      .ram_wr   (ram_wr),
      .ram_dout (ram_dout),
      .ram_din  (ram_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous byte RAM with a backdoor write port used only during reset.
   logic [7:0]    mem [0:(1 << AW) - 1];
   logic          bd_we;
   logic [AW-1:0] bd_a;
   logic [7:0]    bd_d;

   always @(posedge clk) begin
      if (bd_we) mem[bd_a] <= bd_d;
      else if (ram_wr) mem[ram_a] <= ram_dout;
      ram_din <= mem[ram_a];
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        is_mm;
      logic        chk_data;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   logic [24:0] wlog[$];
   int          n_done = 0;

   // Scoreboard: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (ram_wr) wlog.push_back({ram_a, ram_dout});
         if (bus.if_done || bus.mm_done) begin
            n_done++;
            if (sb_q.size() == 0) begin
               chk("spurious_done", 32'({bus.mm_done, bus.if_done}), 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("done_src", 32'({bus.mm_done, bus.if_done}), e.is_mm ? 32'd2 : 32'd1);
               if (e.chk_data) chk("rdata", e.is_mm ? bus.mm_rdata : bus.if_data, e.data);
            end
         end
      end
   end

   task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
      bd_a  = a;
      bd_d  = d;
      bd_we = 1'b1;
      @(posedge clk);
      #1 bd_we = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_done(input logic is_mm, output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!(is_mm ? bus.mm_done : bus.if_done) && lat < 40);
   endtask

   task automatic mm_drive(input logic we, input logic [1:0] size, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata);
      bus.mm_we    = we;
      bus.mm_size  = size;
      bus.mm_sext  = sext;
      bus.mm_addr  = addr;
      bus.mm_wdata = wdata;
      bus.mm_req   = 1'b1;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vt [11];

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      int   lat;
      int   w0;
      int   nd0;
      logic stl_ok;

      rst          = 1'b1;
      bd_we        = 1'b0;
      bd_a         = '0;
      bd_d         = 8'h0;
      bus.if_req   = 1'b0;
      bus.if_addr  = 32'h0;
      bus.mm_req   = 1'b0;
      bus.mm_we    = 1'b0;
      bus.mm_size  = 2'b00;
      bus.mm_sext  = 1'b0;
      bus.mm_addr  = 32'h0;
      bus.mm_wdata = 32'h0;

      vt[0]  = '{1'b1, 2'b10, 1'b0, 32'h200,   32'h11223344, 32'h0,        5};
      vt[1]  = '{1'b0, 2'b10, 1'b0, 32'h200,   32'h0,        32'h11223344, 6};
      vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h40,    32'h0,        32'hFFFFFF80, 3};
      vt[3]  = '{1'b0, 2'b00, 1'b0, 32'h40,    32'h0,        32'h00000080, 3};
      vt[4]  = '{1'b0, 2'b01, 1'b1, 32'h202,   32'h0,        32'h00001122, 4};
      vt[5]  = '{1'b1, 2'b01, 1'b0, 32'h300,   32'hABCD8001, 32'h0,        3};
      vt[6]  = '{1'b0, 2'b01, 1'b1, 32'h300,   32'h0,        32'hFFFF8001, 4};
      vt[7]  = '{1'b0, 2'b11, 1'b1, 32'h200,   32'h0,        32'h11223344, 6};
      vt[8]  = '{1'b0, 2'b00, 1'b1, 32'h201,   32'h0,        32'h00000033, 3};
      vt[9]  = '{1'b0, 2'b10, 1'b0, 32'h1FFFF, 32'h0,        32'hDDCCBBAA, 6};
      vt[10] = '{1'b0, 2'b01, 1'b0, 32'h302,   32'h0,        32'h00007766, 4};

      // Preload while the DUT is held in reset.
      poke(17'h100, 8'h13); poke(17'h101, 8'h05); poke(17'h102, 8'hA0); poke(17'h103, 8'h00);
      poke(17'h40, 8'h80);  poke(17'h22, 8'h5A);
      poke(17'h1FFFF, 8'hAA); poke(17'h0, 8'hBB); poke(17'h1, 8'hCC); poke(17'h2, 8'hDD);
      poke(17'h302, 8'h66); poke(17'h303, 8'h77);
      for (int i = 0; i < 4; i++) poke(AW'(32'h400 + i), 8'h00);
      tick();
      rst = 1'b0;
      tick();

      chk("rst_if_done",  32'(bus.if_done), 32'd0);
      chk("rst_mm_done",  32'(bus.mm_done), 32'd0);
      chk("rst_ram_wr",   32'(ram_wr), 32'd0);
      chk("rst_ram_a",    32'(ram_a), 32'd0);
      chk("rst_ram_dout", 32'(ram_dout), 32'd0);
      chk("rst_if_data",  bus.if_data, 32'd0);
      chk("rst_mm_rdata", bus.mm_rdata, 32'd0);

      // Instruction fetch with stall tracking.
      bus.if_addr = 32'h100;
      bus.if_req  = 1'b1;
      sb_q.push_back('{1'b0, 1'b1, 32'h00A00513});
      #1 chk("fetch_stl_if_req", 32'(bus.stl_if), 32'd1);
      lat    = 0;
      stl_ok = 1'b1;
      do begin
         tick();
         lat++;
         if (!bus.if_done && !bus.stl_if) stl_ok = 1'b0;
      end while (!bus.if_done && lat < 40);
      chk("fetch_lat", 32'(lat), 32'd6);
      chk("fetch_stl_hold", 32'(stl_ok), 32'd1);
      chk("fetch_stl_done", 32'(bus.stl_if), 32'd0);
      bus.if_req = 1'b0;
      tick();

      // Table of memory-stage accesses.
      for (int i = 0; i < 11; i++) begin
         mm_drive(vt[i].we, vt[i].size, vt[i].sext, vt[i].addr, vt[i].wdata);
         sb_q.push_back('{1'b1, !vt[i].we, vt[i].exp});
         wait_done(1'b1, lat);
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
         bus.mm_req = 1'b0;
         tick();
      end

      // Store half: exactly two byte writes, neighbouring byte untouched.
      w0 = wlog.size();
      mm_drive(1'b1, 2'b01, 1'b0, 32'h20, 32'hDEADBEEF);
      sb_q.push_back('{1'b1, 1'b0, 32'h0});
      wait_done(1'b1, lat);
      chk("sth_lat", 32'(lat), 32'd3);
      bus.mm_req = 1'b0;
      tick();
      chk("sth_nwr", 32'(wlog.size() - w0), 32'd2);
      if (wlog.size() >= w0 + 2) begin
         chk("sth_wr0", 32'(wlog[w0]), 32'({17'h20, 8'hEF}));
         chk("sth_wr1", 32'(wlog[w0 + 1]), 32'({17'h21, 8'hBE}));
      end
      chk("sth_ram22", 32'(mem[17'h22]), 32'h5A);

      // Contention: memory stage first, fetch granted in the IDLE after its DONE.
      bus.if_addr = 32'h100;
      bus.if_req  = 1'b1;
      mm_drive(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
      sb_q.push_back('{1'b1, 1'b1, 32'h11223344});
      sb_q.push_back('{1'b0, 1'b1, 32'h00A00513});
      wait_done(1'b1, lat);
      chk("cont_mm_lat", 32'(lat), 32'd6);
      chk("cont_stl_if", 32'(bus.stl_if), 32'd1);
      bus.mm_req = 1'b0;
      wait_done(1'b0, lat);
      chk("cont_if_lat", 32'(lat), 32'd7);
      bus.if_req = 1'b0;
      tick();

      // Reset in the middle of a word store.
      nd0 = n_done;
      mm_drive(1'b1, 2'b10, 1'b0, 32'h400, 32'h55667788);
      tick();
      tick();
      chk("rstx_wr_active", 32'(ram_wr), 32'd1);
      rst = 1'b1;
      tick();
      chk("rstx_ram_wr", 32'(ram_wr), 32'd0);
      chk("rstx_mm_done", 32'(bus.mm_done), 32'd0);
      bus.mm_req = 1'b0;
      rst = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      chk("rstx_no_done", 32'(n_done - nd0), 32'd0);
      chk("rstx_b0", 32'(mem[17'h400]), 32'h88);
      chk("rstx_b2", 32'(mem[17'h402]), 32'h00);
      mm_drive(1'b0, 2'b00, 1'b0, 32'h400, 32'h0);
      sb_q.push_back('{1'b1, 1'b1, 32'h00000088});
      wait_done(1'b1, lat);
      chk("rstx_idle_lat", 32'(lat), 32'd3);
      bus.mm_req = 1'b0;
      tick();
      tick();

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
